pipeline_controller: RTL
========================

Name: pipeline_controller

Overview:
- Pipelined successor to the single-cycle RV32I control unit.
- Decodes op/funct3/funct7b5 in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers, with stall and flush.
- Resolves branches and jumps in EX against the branch-predictor guess and generates redirect/flush and predictor-update signals.
- Sits between the fetch/predictor front end, the hazard unit and the datapath.

Parameters:
ALUCTRL_W, 4, ALUControl width; 4 adds sll/srl/sra/xor/sltu encodings; 3 keeps add/sub/and/or/slt only, others decode illegal.
IMMSRC_W, 3, ImmSrc width; 3 adds U-type (3'b100); 2 treats lui/auipc as illegal.
CNT_W, 32, perf counter width (only with PERF_CNT_EN).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
op_d  in  7  opcode of instruction in ID
funct3_d  in  3  funct3 in ID
funct7b5_d  in  1  instr[30] in ID
stall_e  in  1  hazard unit: hold ID/EX register
flush_e  in  1  hazard unit: load bubble into ID/EX
zero_e, lt_e, ltu_e  in  1 each  ALU compare flags for EX instruction
pred_taken_e  in  1  predictor guess carried with EX instruction
imm_src_d  out  IMMSRC_W  immediate select (combinational, ID)
illegal_d  out  1  unsupported encoding in ID (combinational)
alu_control_e  out  ALUCTRL_W  ALU operation, EX
alu_src_e  out  1  ALU B = immediate
result_src_e0  out  1  EX instruction is a load (load-use detection)
reg_write_m, reg_write_w  out  1 each  register write enables, MEM/WB
mem_write_m  out  1  store enable, MEM
result_src_w  out  2  00 ALU, 01 mem, 10 PC+4
redirect_e  out  1  mispredict: redirect fetch and flush IF/ID
redirect_sel_e  out  2  00 PC+imm, 01 rs1+imm (jalr), 10 PC+4
bp_update_e  out  1  EX holds a conditional branch or jal (predictor write)
bp_taken_e  out  1  actual outcome for update
br_count, mispred_count  out  CNT_W each  perf counters (see Optional Feature)

Behaviour:
- Decode (ID) is combinational: R, I-ALU, load, store, branch, jal and jalr; lui/auipc only when IMMSRC_W=3. Any other opcode, or any funct3/funct7 combination unsupported at the current ALUCTRL_W, sets illegal_d=1 and the control word becomes a bubble.
- Bubble = all of RegWrite, MemWrite, Branch, Jump, jalr cleared to 0; other fields 0.
- ID/EX update priority each clock:
  1. rst_n=0: bubble.
  2. Else redirect_e=1 or flush_e=1: bubble.
  3. Else stall_e=1: hold.
  4. Else load decoded word.
  - Flush beats stall.
- EX/MEM and MEM/WB advance every cycle and reset to bubble. Latency: ID decode to reg_write_w is exactly 3 clocks with no stall.
- Branch condition in EX by funct3 (the only legal branch funct3 values):
  - 000 beq: zero_e
  - 001 bne: !zero_e
  - 100 blt: lt_e
  - 101 bge: !lt_e
  - 110 bltu: ltu_e
  - 111 bgeu: !ltu_e
- taken_e = (Branch & cond) | Jump | jalr.
- Redirect and predictor update, all combinational in EX and gated to 0 for a bubble:
  - Branch/jal: redirect_e = (taken_e != pred_taken_e); redirect_sel_e = taken_e ? 00 : 10.
  - jalr: redirect_e = 1 always; redirect_sel_e = 01.
  - bp_update_e = Branch | Jump (not jalr); bp_taken_e = taken_e.
- A redirect with stall_e=1 still loads a bubble (the wrong-path ID instruction is killed).
- Reset mid-operation: all stages become bubbles on the next edge; no write enable is asserted in the cycle after rst_n rises.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - br_count increments on each cycle bp_update_e=1.
  - mispred_count increments on each cycle redirect_e=1.
  - Both wrap at 2^CNT_W and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- add x1,x2,x3 (op 0110011, f3 000, f7b5 0) with no stall: alu_control_e=0000 one cycle later; reg_write_w=1 and result_src_w=00 exactly 3 cycles after ID.
- beq with zero_e=1, pred_taken_e=0: redirect_e=1, redirect_sel_e=00, bp_update_e=1, bp_taken_e=1; next ID/EX is a bubble, so that instruction's reg_write_w=0.
- bge with lt_e=1, pred_taken_e=1: redirect_e=1, redirect_sel_e=10. Same branch with pred_taken_e=0: redirect_e=0.
- lw followed by stall_e=1 for 1 cycle: result_src_e0=1 held 2 cycles; then stall_e=1 with flush_e=1 together loads a bubble (flush priority).
- Illegal op 0001111: illegal_d=1, no write enables downstream. With ALUCTRL_W=3, sll sets illegal_d=1.
- Feature on: 5 branches, 2 mispredicted plus 1 jalr gives br_count=5, mispred_count=3; rst_n=0 for 1 cycle clears both to 0.

Source files
------------

// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//
// Pipelined RV32I control unit. Decodes the instruction in ID, carries the
// control word through ID/EX, EX/MEM and MEM/WB, and resolves branches and
// jumps in EX against the predictor's guess.
//
// Parameters
//   ALUCTRL_W : ALU op width. 4 = full set, 3 = add/sub/and/or/slt only
//               (sll/srl/sra/xor/sltu decode as illegal).
//   IMMSRC_W  : ImmSrc width. 3 = U-type supported, 2 = lui/auipc illegal.
//   CNT_W     : perf counter width.
//
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN
//   defined   -> br_count / mispred_count are live wrapping counters
//   undefined -> both tied to 0, no counter flops
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   op_d, funct3_d, funct7b5_d    instruction fields in ID
//   stall_e, flush_e              hazard unit controls for ID/EX
//   zero_e, lt_e, ltu_e           ALU compare flags for the EX instruction
//   pred_taken_e                  predictor guess for the EX instruction
//   imm_src_d, illegal_d          ID decode (combinational)
//   alu_control_e, alu_src_e      EX ALU controls
//   result_src_e0                 EX instruction is a load
//   reg_write_m, mem_write_m      MEM stage enables
//   reg_write_w, result_src_w     WB stage controls
//   redirect_e, redirect_sel_e    mispredict redirect and target select
//   bp_update_e, bp_taken_e       predictor update strobe and outcome
//   br_count, mispred_count       perf counters
//
// Encodings
//   ALU op : 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt,
//            0110 sll, 0111 srl, 1000 sra, 1001 sltu
//   ImmSrc : 000 I, 001 S, 010 B, 011 J, 100 U
//   Loads accept funct3 000/001/010/100/101, stores 000/001/010,
//   jalr 000; jal/lui/auipc carry immediate bits there and ignore them.
// ---------------------------------------------------------------------------
module pipeline_controller #(
  parameter int ALUCTRL_W = 4,
  parameter int IMMSRC_W  = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op_d,
  input  logic [2:0]           funct3_d,
  input  logic                 funct7b5_d,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  input  logic                 pred_taken_e,
  output logic [IMMSRC_W-1:0]  imm_src_d,
  output logic                 illegal_d,
  output logic [ALUCTRL_W-1:0] alu_control_e,
  output logic                 alu_src_e,
  output logic                 result_src_e0,
  output logic                 reg_write_m,
  output logic                 reg_write_w,
  output logic                 mem_write_m,
  output logic [1:0]           result_src_w,
  output logic                 redirect_e,
  output logic [1:0]           redirect_sel_e,
  output logic                 bp_update_e,
  output logic                 bp_taken_e,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // The control word is always carried at full 4-bit ALU width; narrowing
  // to ALUCTRL_W only happens at the output, and narrow builds never let an
  // extended op through decode.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Returns {bad, extended, alu_op}. For I-type, funct7b5 is an immediate
  // bit except on shifts, where it selects srai and must be 0 for slli.
  function automatic logic [5:0] alu_dec(input logic [2:0] f3,
                                         input logic       f7b5,
                                         input logic       is_r);
    logic       f_bad;
    logic       f_ext;
    logic [3:0] f_op;
    f_bad = 1'b0;
    f_ext = 1'b0;
    f_op  = ALU_ADD;
    case (f3)
      3'b000: f_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: begin f_op = ALU_SLL;  f_ext = 1'b1; f_bad = f7b5;        end
      3'b010: begin f_op = ALU_SLT;                f_bad = is_r & f7b5; end
      3'b011: begin f_op = ALU_SLTU; f_ext = 1'b1; f_bad = is_r & f7b5; end
      3'b100: begin f_op = ALU_XOR;  f_ext = 1'b1; f_bad = is_r & f7b5; end
      3'b101: begin f_op = f7b5 ? ALU_SRA : ALU_SRL; f_ext = 1'b1;      end
      3'b110: begin f_op = ALU_OR;                 f_bad = is_r & f7b5; end
      default: begin f_op = ALU_AND;               f_bad = is_r & f7b5; end
    endcase
    return {f_bad, f_ext, f_op};
  endfunction

  // ---------------------------------------------------------------- ID ----
  ctrl_t      dec;
  ctrl_t      dec_word;
  logic [2:0] imm3;
  logic       bad;
  logic       ext;
  logic       utype;

  always_comb begin
    dec        = BUBBLE;
    dec.funct3 = funct3_d;
    imm3       = 3'b000;
    bad        = 1'b0;
    ext        = 1'b0;
    utype      = 1'b0;
    case (op_d)
      OP_R: begin
        {bad, ext, dec.alu_op} = alu_dec(funct3_d, funct7b5_d, 1'b1);
        dec.reg_write = 1'b1;
      end
      OP_I: begin
        {bad, ext, dec.alu_op} = alu_dec(funct3_d, funct7b5_d, 1'b0);
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        // lb/lh/lw/lbu/lhu only
        bad = (funct3_d == 3'b011) || (funct3_d[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm3          = 3'b001;
        bad           = funct3_d[2] || (funct3_d[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        imm3       = 3'b010;
        bad        = (funct3_d[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        imm3           = 3'b011;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
        bad            = (funct3_d != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm3          = 3'b100;
        utype         = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  assign illegal_d = bad || (ext && (ALUCTRL_W < 4)) || (utype && (IMMSRC_W < 3));
  assign dec_word  = illegal_d ? BUBBLE : dec;
  assign imm_src_d = illegal_d ? '0 : IMMSRC_W'(imm3);

  // ---------------------------------------------------------------- EX ----
  ctrl_t ex;
  logic  cond_e;
  logic  taken_e;

  // redirect_e is fed back here so the wrong-path ID instruction is killed
  // even if the hazard unit is stalling at the same time.
  always_ff @(posedge clk) begin
    if (!rst_n)                      ex <= BUBBLE;
    else if (redirect_e || flush_e)  ex <= BUBBLE;
    else if (!stall_e)               ex <= dec_word;
  end

  always_comb begin
    case (ex.funct3)
      3'b000:  cond_e = zero_e;
      3'b001:  cond_e = !zero_e;
      3'b100:  cond_e = lt_e;
      3'b101:  cond_e = !lt_e;
      3'b110:  cond_e = ltu_e;
      3'b111:  cond_e = !ltu_e;
      default: cond_e = 1'b0;
    endcase
  end

  // A bubble has branch/jump/jalr clear, so every EX resolution output
  // below falls to 0 for it without extra gating.
  assign taken_e = (ex.branch & cond_e) | ex.jump | ex.jalr;

  always_comb begin
    redirect_e     = 1'b0;
    redirect_sel_e = 2'b00;
    if (ex.jalr) begin
      // target is register-dependent; the front end never predicts it
      redirect_e     = 1'b1;
      redirect_sel_e = 2'b01;
    end else if (ex.branch || ex.jump) begin
      redirect_e     = taken_e ^ pred_taken_e;
      redirect_sel_e = taken_e ? 2'b00 : 2'b10;
    end
  end

  assign bp_update_e   = ex.branch | ex.jump;
  assign bp_taken_e    = taken_e;
  assign alu_control_e = ALUCTRL_W'(ex.alu_op);
  assign alu_src_e     = ex.alu_src;
  assign result_src_e0 = ex.result_src[0];

  // --------------------------------------------------------- MEM / WB ----
  logic [1:0] result_src_m;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
    end else begin
      reg_write_m  <= ex.reg_write;
      mem_write_m  <= ex.mem_write;
      result_src_m <= ex.result_src;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end

  // ------------------------------------------------------ perf counters ----
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (bp_update_e) br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (redirect_e)  mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule
